// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared func3 encodings, state encoding and alignment helper
//               for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_BUSY = 2'd1;
    localparam lsu_state_t ST_DONE = 2'd2;

    // Only the size bits matter; unlisted size codes are treated as words.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = offset[0];
            default: bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Selects the addressed byte/half lane of a memory word and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (func3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Handshaked data-memory front end with byte strobes, load
//               extension, alignment checking and a request timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

    lsu_state_t       state;
    lsu_state_t       next_state;
    logic             access;
    logic             align_err;
    logic             launch;
    logic             timed_out;
    logic [CNT_W-1:0] count;
    logic [2:0]       lat_func3;
    logic [1:0]       lat_offset;
    logic [3:0]       store_strb;
    logic [31:0]      store_data;
    logic [31:0]      load_data;

    assign access    = mem_read | mem_write;
    assign align_err = is_misaligned(func3[1:0], addr[1:0]);
    assign launch    = (state == ST_IDLE) && access && !align_err;
    assign timed_out = (count == LAST_COUNT);

    // Store lane steering; the memory only writes lanes whose strobe is set.
    always_comb begin
        case (func3)
            F3_B: begin
                store_strb = 4'b0001 << addr[1:0];
                store_data = {4{wdata[7:0]}};
            end
            F3_H: begin
                store_strb = 4'b0011 << addr[1:0];
                store_data = {2{wdata[15:0]}};
            end
            default: begin
                store_strb = 4'b1111;
                store_data = wdata;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .func3  (lat_func3),
        .offset (lat_offset),
        .word   (mem_rdata),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE always falls back to IDLE so the still-asserted request of the
    // same instruction cannot launch a second access.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready || timed_out) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req    = (state == ST_BUSY);
        done       = (state == ST_DONE);
        stall      = launch || (state == ST_BUSY);
        misaligned = (state == ST_IDLE) && access && align_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= 32'd0;
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'd0;
            mem_wdata  <= 32'd0;
            lat_func3  <= 3'd0;
            lat_offset <= 2'd0;
            rdata      <= 32'd0;
            bus_err    <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        mem_addr   <= {addr[31:2], 2'b00};
                        mem_we     <= mem_write;
                        mem_wstrb  <= mem_write ? store_strb : 4'd0;
                        mem_wdata  <= store_data;
                        lat_func3  <= func3;
                        lat_offset <= addr[1:0];
                        count      <= '0;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            rdata <= load_data;
                        end
                    end else if (timed_out) begin
                        bus_err <= 1'b1;
                        rdata   <= 32'd0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    bus_err <= 1'b0;
                    count   <= '0;
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed scoreboard bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        done;
    logic        stall;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    req_t  exp_req[$];
    resp_t exp_resp[$];
    logic  prev_req = 1'b0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .func3      (func3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .done       (done),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Request monitor: compares the latched memory request on the first BUSY cycle.
    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            if (exp_req.size() == 0) begin
                check("unexpected_mem_req", 32'd1, 32'd0);
            end else begin
                req_t r;
                r = exp_req.pop_front();
                check("mem_addr", mem_addr, r.addr);
                check("mem_we", {31'd0, mem_we}, {31'd0, r.we});
                check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, r.strb});
                if (r.we) check("mem_wdata", mem_wdata, r.wdata);
            end
        end
        prev_req = mem_req;
    end

    // Response monitor: compares result data whenever done is presented.
    always @(negedge clk) begin
        if (done) begin
            if (exp_resp.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = exp_resp.pop_front();
                check("rdata", rdata, e.rdata);
                check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                check("stall_at_done", {31'd0, stall}, 32'd0);
            end
        end
    end

    // k = BUSY cycle (1-based) in which mem_ready is raised; k <= 0 never raises it.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input int k,
                              input logic [31:0] mrd, input logic [31:0] exp_rd,
                              input logic exp_err, input logic [31:0] exp_addr,
                              input logic exp_we, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wd);
        int stall_cnt;
        int req_cnt;
        bit seen_done;
        req_t  r;
        resp_t p;
        r.addr = exp_addr; r.we = exp_we; r.strb = exp_strb; r.wdata = exp_wd;
        p.rdata = exp_rd; p.err = exp_err;
        exp_req.push_back(r);
        exp_resp.push_back(p);
        stall_cnt = 0;
        req_cnt = 0;
        seen_done = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
        mem_rdata = mrd;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (stall) stall_cnt++;
            if (mem_req) req_cnt++;
            if (done) begin
                seen_done = 1;
                break;
            end
            mem_ready = mem_req && (k > 0) && (req_cnt == k);
            @(negedge clk);
            #1;
        end
        if (!seen_done) check("done_within_bound", 32'd0, 32'd1);
        check("stall_cycles", stall_cnt, 1 + ((k > 0) ? k : 16));
        check("req_cycles", req_cnt, (k > 0) ? k : 16);
        // Request stays high through the IDLE-return edge, as the datapath would.
        @(negedge clk);
        mem_read = 0; mem_write = 0; mem_ready = 0;
    endtask

    initial begin
        #3;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 0;

        run_access(1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 0,
                   32'h100, 0, 4'b0000, 32'h0);
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF1234, 32'hFFFFFF80, 0,
                   32'h100, 0, 4'b0000, 32'h0);
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF1234, 32'h00000080, 0,
                   32'h100, 0, 4'b0000, 32'h0);
        run_access(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 1, 32'h0, 32'h00000080, 0,
                   32'h20, 1, 4'b1100, 32'hABCDABCD);

        // Misaligned word load: flagged, no stall, no memory activity.
        @(negedge clk);
        mem_read = 1; func3 = 3'b010; addr = 32'h102;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("misaligned", {31'd0, misaligned}, 32'd1);
            check("misaligned_stall", {31'd0, stall}, 32'd0);
            check("misaligned_req", {31'd0, mem_req}, 32'd0);
            @(negedge clk);
        end
        mem_read = 0;

        // Read and write together is a write; memory never answers.
        run_access(1, 1, 3'b010, 32'h40, 32'h11223344, 0, 32'h0, 32'h0, 1,
                   32'h40, 1, 4'b1111, 32'h11223344);
        run_access(1, 0, 3'b001, 32'h102, 32'h0, 3, 32'h80010000, 32'hFFFF8001, 0,
                   32'h100, 0, 4'b0000, 32'h0);
        run_access(1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h80010000, 32'h00008001, 0,
                   32'h100, 0, 4'b0000, 32'h0);
        run_access(0, 1, 3'b000, 32'h41, 32'hFFFFFF5A, 1, 32'h0, 32'h00008001, 0,
                   32'h40, 1, 4'b0010, 32'h5A5A5A5A);
        run_access(1, 0, 3'b001, 32'h200, 32'h0, 1, 32'h12347FFF, 32'h00007FFF, 0,
                   32'h200, 0, 4'b0000, 32'h0);

        // Reset while BUSY: request must drop without waiting for a clock edge.
        begin
            req_t r;
            r.addr = 32'h300; r.we = 0; r.strb = 4'b0000; r.wdata = 32'h0;
            exp_req.push_back(r);
        end
        @(negedge clk);
        mem_read = 1; func3 = 3'b010; addr = 32'h300;
        for (int i = 0; i < 5 && !mem_req; i++) begin
            @(negedge clk);
            #1;
        end
        check("req_before_reset", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1;
        #1;
        check("async_reset_req", {31'd0, mem_req}, 32'd0);
        check("async_reset_done", {31'd0, done}, 32'd0);
        check("async_reset_addr", mem_addr, 32'd0);
        mem_read = 0;
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);

        run_access(1, 0, 3'b010, 32'h200, 32'h0, 1, 32'h12345678, 32'h12345678, 0,
                   32'h200, 0, 4'b0000, 32'h0);

        repeat (3) @(negedge clk);
        check("pending_requests", exp_req.size(), 32'd0);
        check("pending_responses", exp_resp.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the single-cycle datapath and a handshaked data memory, replacing the fixed-latency DataMem hookup. Takes the datapath's address (ALUResult), store data (RD2), func3 and MemWrite/MemRead. Drives a ready/handshaked memory port with byte strobes and returns sign- or zero-extended load data. Stalls the PC/register-file write while an access is outstanding.

Parameters:
TIMEOUT, 16, max cycles waiting for mem_ready before the access is aborted with bus_err
CNT_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_read  in  1  load request from controller
mem_write  in  1  store request from controller
func3  in  3  Instr[14:12]: access size/signedness
addr  in  32  byte address (ALUResult)
wdata  in  32  store data (RD2)
rdata  out  32  extended load data, valid when done=1
done  out  1  access completed this cycle
stall  out  1  hold PC and inhibit RegWrite
misaligned  out  1  illegal alignment; no memory access issued
bus_err  out  1  timeout abort, valid with done
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  32  word address {addr[31:2],2'b00}, latched
mem_wstrb  out  4  byte lane enables
mem_wdata  out  32  lane-replicated store data, latched
mem_ready  in  1  memory accepts/completes request
mem_rdata  in  32  memory word read data

Behaviour:
- Reset (async, rst=1): state IDLE; mem_req, mem_we, done, bus_err = 0; mem_wstrb = 0; rdata, mem_addr, mem_wdata = 0; counter = 0. Reset mid-access drops mem_req immediately; the access is abandoned.
- States: IDLE, BUSY, DONE.
- access = mem_read | mem_write. If both are high, the access is a write.
- Alignment check (combinational):
  - Halfword (func3[1:0]=01) with addr[0]=1 is misaligned.
  - Word (func3[1:0]=10, or any unlisted code) with addr[1:0]!=0 is misaligned.
- IDLE:
  - If access and misaligned: misaligned=1, stall=0, no transition, no memory activity.
  - If access and aligned: stall=1. Latch mem_addr, mem_we, mem_wstrb, mem_wdata, func3 and addr[1:0]. Go to BUSY.
- BUSY:
  - mem_req=1 (registered), stall=1, counter increments each cycle.
  - On mem_ready=1: capture the extended mem_rdata into rdata (loads only; stores leave rdata unchanged). Go to DONE, mem_req=0.
  - If the counter reaches TIMEOUT-1 without mem_ready: go to DONE, set bus_err=1, rdata=0, mem_req=0.
- DONE:
  - done=1 for exactly one cycle, stall=0; the datapath writes back and advances the PC at this edge.
  - Always returns to IDLE. It never launches a new access, even though access is still high for the same instruction.
  - bus_err clears on exit; counter clears.
- Latency: access issued in IDLE gives mem_req on the next cycle and done on the cycle after mem_ready. Minimum 3 cycles per access (IDLE→BUSY→DONE).
- Store strobes:
  - SB (000): 4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}
  - SH (001): 4'b0011<<addr[1:0], mem_wdata={2{wdata[15:0]}}
  - SW (010 or other): 4'b1111, mem_wdata=wdata
  - Loads: mem_wstrb=0, mem_we=0.
- Load extract: select byte/half lane by latched addr[1:0].
  - LB (000): sign-extend byte
  - LH (001): sign-extend half
  - LBU (100): zero-extend byte
  - LHU (101): zero-extend half
  - LW (010 and all others): whole word
- mem_ready outside BUSY is ignored.

Decomposition:
- Shared package holds:
  - func3 encodings: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - state encoding: IDLE/BUSY/DONE as 2-bit constants
- One natural sub-module: lsu_load_align. It is combinational: latched func3 + byte offset + mem_rdata → extended rdata.
- Strobe/replication logic stays inline.

Test Plan:
- LW, addr=0x100, mem_ready after 2 BUSY cycles, mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_wstrb=0. Then done=1 with rdata=0xDEADBEEF, stall high on exactly the 3 cycles before done.
- LB/LBU, addr=0x103, mem_rdata=0x80FF_1234 → LB rdata=0xFFFFFF80, LBU rdata=0x00000080.
- SH, addr=0x22, wdata=0x0000ABCD, mem_ready immediate → mem_we=1, mem_addr=0x20, mem_wstrb=4'b1100, mem_wdata=0xABCDABCD. Then done=1.
- LW, addr=0x102 → misaligned=1, stall=0, mem_req never asserted, state stays IDLE.
- SW with mem_ready held 0 → mem_req high for 16 cycles, then done=1, bus_err=1, rdata=0, back to IDLE.
- rst pulsed while BUSY → mem_req=0 in the same cycle (async), state IDLE. A subsequent LW completes normally.
